// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller.
//   state_t   : hazard controller FSM state (RUN, DMEM_WAIT)
//   reg_idx_t : architectural register index (x0..x31)
//   REG_ZERO  : index of the hard-wired zero register
package cpu_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    DMEM_WAIT = 1'b1
  } state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the count
//   inc    : add one at the next clock edge
//   count  : current count, holds at 2^W-1 instead of wrapping
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, sitting beside ID.
// Resolves hazards that EX bypassing cannot: load-use (one bubble),
// taken branches resolved in ID (IF/ID flush) and data-memory wait
// (global freeze). Also keeps saturating event counters and a
// memory-wait watchdog.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   rs1_IFID, rs2_IFID      : source registers of the ID instruction
//   use_rs2_IFID            : ID instruction actually reads rs2
//   rd_IDEX, MemRead_IDEX   : destination / load flag of the EX instruction
//   MemReq_EXMEM            : MEM instruction accesses data memory
//   dmem_ready_i            : data memory completes this cycle
//   branch_taken_i          : branch in ID resolved taken
//   PCWrite_o, IFIDWrite_o  : PC and IF/ID write enables
//   NoOp_o                  : inject a bubble into ID/EX
//   IFID_flush_o            : clear IF/ID
//   stall_all_o             : freeze all pipeline registers and the PC
//   stall_cnt_o, freeze_cnt_o, flush_cnt_o : saturating event counters
//   dmem_timeout_o          : sticky watchdog flag
//
// state     | meaning
// ----------+-----------------------------------------------------
// RUN       | normal flow; a memory access may still stall here
// DMEM_WAIT | data memory busy, pipeline frozen until ready
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_IFID,
  input  logic [4:0]       rs2_IFID,
  input  logic             use_rs2_IFID,
  input  logic [4:0]       rd_IDEX,
  input  logic             MemRead_IDEX,
  input  logic             MemReq_EXMEM,
  input  logic             dmem_ready_i,
  input  logic             branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             IFID_flush_o,
  output logic             stall_all_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             dmem_timeout_o
);

  localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;

  logic freeze;
  logic load_use;

  always_comb begin
    freeze = ((state_q == RUN) && MemReq_EXMEM && !dmem_ready_i) ||
             ((state_q == DMEM_WAIT) && !dmem_ready_i);

    load_use = MemRead_IDEX && (reg_idx_t'(rd_IDEX) != REG_ZERO) &&
               ((rd_IDEX == rs1_IFID) ||
                (use_rs2_IFID && (rd_IDEX == rs2_IFID)));

    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    NoOp_o       = 1'b0;
    IFID_flush_o = 1'b0;
    stall_all_o  = 1'b0;

    if (rst_i) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
      stall_all_o = 1'b1;
    end else if (freeze) begin
      // ID is frozen, so a taken branch is simply presented again later.
      stall_all_o = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (load_use) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        // A ready access in RUN is zero-wait and never leaves RUN.
        if (MemReq_EXMEM && !dmem_ready_i) begin
          state_d = DMEM_WAIT;
          wait_d  = '0;
        end
      end
      DMEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d = RUN;
        end
        if (wait_q != '1) begin
          wait_d = wait_q + 32'd1;
        end
        if ((TIMEOUT_L != 32'd0) && (wait_d == TIMEOUT_L)) begin
          timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign dmem_timeout_o = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (NoOp_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_all_o),
    .count (freeze_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (IFID_flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = 15;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic noop;
    logic flush;
    logic stall;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] fr;
    logic [3:0] fl;
    logic       to;
  } cnt_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [4:0]       rs1_IFID = '0;
  logic [4:0]       rs2_IFID = '0;
  logic             use_rs2_IFID = 1'b0;
  logic [4:0]       rd_IDEX = '0;
  logic             MemRead_IDEX = 1'b0;
  logic             MemReq_EXMEM = 1'b0;
  logic             dmem_ready_i = 1'b0;
  logic             branch_taken_i = 1'b0;
  logic             PCWrite_o, IFIDWrite_o, NoOp_o, IFID_flush_o, stall_all_o;
  logic [CNT_W-1:0] stall_cnt_o, freeze_cnt_o, flush_cnt_o;
  logic             dmem_timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  ctl_t ctl_q[$];
  cnt_t cnt_q[$];

  // reference model state
  int m_state = 0;
  int m_wait  = 0;
  int m_to    = 0;
  int m_st    = 0;
  int m_fr    = 0;
  int m_fl    = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rs1_IFID       (rs1_IFID),
    .rs2_IFID       (rs2_IFID),
    .use_rs2_IFID   (use_rs2_IFID),
    .rd_IDEX        (rd_IDEX),
    .MemRead_IDEX   (MemRead_IDEX),
    .MemReq_EXMEM   (MemReq_EXMEM),
    .dmem_ready_i   (dmem_ready_i),
    .branch_taken_i (branch_taken_i),
    .PCWrite_o      (PCWrite_o),
    .IFIDWrite_o    (IFIDWrite_o),
    .NoOp_o         (NoOp_o),
    .IFID_flush_o   (IFID_flush_o),
    .stall_all_o    (stall_all_o),
    .stall_cnt_o    (stall_cnt_o),
    .freeze_cnt_o   (freeze_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .dmem_timeout_o (dmem_timeout_o)
  );

  function automatic int sat_inc(input int v, input logic en);
    if (en && v < CMAX) return v + 1;
    return v;
  endfunction

  // One clock cycle: drive inputs, predict, compare controls before the edge
  // and counters/flag after it.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic use2, input logic [4:0] rd, input logic mr,
                      input logic req, input logic rdy, input logic br,
                      output ctl_t obs);
    ctl_t e, got_e;
    cnt_t ec, gc;
    logic fz, lu;
    @(negedge clk_i);
    rst_i = rst; rs1_IFID = rs1; rs2_IFID = rs2; use_rs2_IFID = use2;
    rd_IDEX = rd; MemRead_IDEX = mr; MemReq_EXMEM = req;
    dmem_ready_i = rdy; branch_taken_i = br;

    fz = (m_state == 0 && req && !rdy) || (m_state == 1 && !rdy);
    lu = mr && rd != 5'd0 && (rd == rs1 || (use2 && rd == rs2));
    if (rst)      e = '{pc:0, ifid:0, noop:1, flush:0, stall:1};
    else if (fz)  e = '{pc:0, ifid:0, noop:0, flush:0, stall:1};
    else if (lu)  e = '{pc:0, ifid:0, noop:1, flush:0, stall:0};
    else if (br)  e = '{pc:1, ifid:1, noop:0, flush:1, stall:0};
    else          e = '{pc:1, ifid:1, noop:0, flush:0, stall:0};
    ctl_q.push_back(e);

    #1;
    obs = '{pc:PCWrite_o, ifid:IFIDWrite_o, noop:NoOp_o, flush:IFID_flush_o, stall:stall_all_o};
    got_e = ctl_q.pop_front();
    n_checks++;
    if (obs !== got_e) begin
      n_errors++;
      $display("FAIL ctl @%0t: got pc/ifid/noop/flush/stall=%b required %b", $time, obs, got_e);
    end

    @(posedge clk_i);
    if (rst) begin
      m_state = 0; m_wait = 0; m_to = 0; m_st = 0; m_fr = 0; m_fl = 0;
    end else begin
      m_st = sat_inc(m_st, e.noop);
      m_fr = sat_inc(m_fr, e.stall);
      m_fl = sat_inc(m_fl, e.flush);
      if (m_state == 0) begin
        if (req && !rdy) begin m_state = 1; m_wait = 0; end
      end else begin
        m_wait = m_wait + 1;
        if (TIMEOUT != 0 && m_wait == TIMEOUT) m_to = 1;
        if (rdy) m_state = 0;
      end
    end
    ec = '{st:4'(m_st), fr:4'(m_fr), fl:4'(m_fl), to:m_to[0]};
    cnt_q.push_back(ec);

    #1;
    gc = '{st:stall_cnt_o, fr:freeze_cnt_o, fl:flush_cnt_o, to:dmem_timeout_o};
    ec = cnt_q.pop_front();
    n_checks++;
    if (gc !== ec) begin
      n_errors++;
      $display("FAIL cnt @%0t: got st/fr/fl/to=%0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
               $time, gc.st, gc.fr, gc.fl, gc.to, ec.st, ec.fr, ec.fl, ec.to);
    end
  endtask

  task automatic idle(input logic rst, output ctl_t obs);
    step(rst, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, obs);
  endtask

  task automatic test_reset();
    ctl_t o;
    idle(1'b1, o);
    idle(1'b1, o);
    n_checks++;
    if (o !== 5'b00101 || stall_cnt_o !== 4'd0 || dmem_timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: got ctl=%b st=%0d to=%b required ctl=00101 st=0 to=0",
               o, stall_cnt_o, dmem_timeout_o);
    end
    idle(1'b0, o);
  endtask

  task automatic test_load_use();
    ctl_t o;
    // rs1 match
    step(0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 1, 0, o);
    n_checks++;
    if (o.pc !== 1'b0 || o.noop !== 1'b1 || stall_cnt_o !== 4'd1) begin
      n_errors++;
      $display("FAIL lu_rs1: got pc=%b noop=%b st=%0d required pc=0 noop=1 st=1",
               o.pc, o.noop, stall_cnt_o);
    end
    // bubble now in EX
    step(0, 5'd5, 5'd0, 0, 5'd0, 0, 0, 1, 0, o);
    // rd = x0: no stall
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 1, 0, o);
    n_checks++;
    if (o.noop !== 1'b0) begin
      n_errors++;
      $display("FAIL lu_x0: got noop=%b required 0", o.noop);
    end
    // rs2 match but rs2 unused
    step(0, 5'd1, 5'd7, 0, 5'd7, 1, 0, 1, 0, o);
    // rs2 match with rs2 used
    step(0, 5'd1, 5'd7, 1, 5'd7, 1, 0, 1, 0, o);
    n_checks++;
    if (stall_cnt_o !== 4'd2) begin
      n_errors++;
      $display("FAIL lu_rs2: got st=%0d required 2", stall_cnt_o);
    end
  endtask

  task automatic test_branch();
    ctl_t o;
    idle(1'b1, o);
    step(0, 5'd1, 5'd2, 1, 5'd3, 1, 0, 1, 1, o);
    n_checks++;
    if (o.flush !== 1'b1 || flush_cnt_o !== 4'd1) begin
      n_errors++;
      $display("FAIL branch: got flush=%b fl=%0d required flush=1 fl=1", o.flush, flush_cnt_o);
    end
    idle(1'b0, o);
  endtask

  task automatic test_freeze();
    ctl_t o;
    int highs = 0;
    idle(1'b1, o);
    for (int i = 0; i < 3; i++) begin
      step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
      highs += int'(o.stall);
    end
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, o);
    highs += int'(o.stall);
    n_checks++;
    if (highs != 3 || freeze_cnt_o !== 4'd3) begin
      n_errors++;
      $display("FAIL freeze: got highs=%0d fr=%0d required 3/3", highs, freeze_cnt_o);
    end
    // back in RUN: a busy memory without a request must not freeze
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, o);
    n_checks++;
    if (o.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL freeze_exit: got stall=%b required 0", o.stall);
    end
  endtask

  task automatic test_priority();
    ctl_t o;
    idle(1'b1, o);
    step(0, 5'd4, 5'd0, 0, 5'd4, 1, 1, 0, 1, o);
    step(0, 5'd4, 5'd0, 0, 5'd4, 1, 1, 0, 1, o);
    n_checks++;
    if (o !== 5'b00001) begin
      n_errors++;
      $display("FAIL prio_freeze: got %b required 00001", o);
    end
    step(0, 5'd4, 5'd0, 0, 5'd4, 1, 1, 1, 1, o);
    n_checks++;
    if (o !== 5'b00100) begin
      n_errors++;
      $display("FAIL prio_lu: got %b required 00100", o);
    end
    step(0, 5'd4, 5'd0, 0, 5'd0, 0, 0, 1, 1, o);
    n_checks++;
    if (o !== 5'b11010) begin
      n_errors++;
      $display("FAIL prio_flush: got %b required 11010", o);
    end
  endtask

  task automatic test_timeout();
    ctl_t o;
    idle(1'b1, o);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
    for (int i = 0; i < 3; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
    n_checks++;
    if (dmem_timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL to_early: got %b required 0", dmem_timeout_o);
    end
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
    n_checks++;
    if (dmem_timeout_o !== 1'b1) begin
      n_errors++;
      $display("FAIL to_set: got %b required 1", dmem_timeout_o);
    end
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, o);
    idle(1'b0, o);
    n_checks++;
    if (dmem_timeout_o !== 1'b1) begin
      n_errors++;
      $display("FAIL to_sticky: got %b required 1", dmem_timeout_o);
    end
    // reset in the middle of a freeze
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, o);
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, o);
    n_checks++;
    if (dmem_timeout_o !== 1'b0 || freeze_cnt_o !== 4'd0) begin
      n_errors++;
      $display("FAIL rst_mid: got to=%b fr=%0d required 0/0", dmem_timeout_o, freeze_cnt_o);
    end
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, o);
    n_checks++;
    if (o.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_state: got stall=%b required 0", o.stall);
    end
  endtask

  task automatic test_saturation();
    ctl_t o;
    idle(1'b1, o);
    for (int i = 0; i < 20; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, o);
    n_checks++;
    if (flush_cnt_o !== 4'd15) begin
      n_errors++;
      $display("FAIL saturate: got %0d required 15", flush_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    ctl_t o;
    idle(1'b1, o);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), o);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_priority();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline; complements the EX-stage bypass logic by handling hazards that bypassing cannot resolve.
- Detects load-use hazards in ID, flushes IF/ID on taken branches resolved in ID, and freezes the whole pipeline while data memory is busy.
- Keeps saturating performance counters and a memory-wait watchdog.
- Sits beside the ID stage; outputs drive PC, IF/ID, ID/EX and the global stall enable.

Parameters:
- CNT_W, 32, width of each performance counter.
- TIMEOUT, 0, memory-wait watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- rs1_IFID  in  5  rs1 of the instruction in ID.
- rs2_IFID  in  5  rs2 of the instruction in ID.
- use_rs2_IFID  in  1  ID instruction reads rs2 (R-type, S-type, B-type).
- rd_IDEX  in  5  rd of the instruction in EX.
- MemRead_IDEX  in  1  EX instruction is a load.
- MemReq_EXMEM  in  1  MEM instruction accesses data memory.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- branch_taken_i  in  1  branch in ID resolved taken.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- NoOp_o  out  1  insert a bubble into ID/EX (zero control bits).
- IFID_flush_o  out  1  clear IF/ID.
- stall_all_o  out  1  freeze every pipeline register and the PC.
- stall_cnt_o  out  CNT_W  load-use bubble count.
- freeze_cnt_o  out  CNT_W  memory-freeze cycle count.
- flush_cnt_o  out  CNT_W  branch flush count.
- dmem_timeout_o  out  1  sticky watchdog error flag.

Behaviour:
- FSM states: RUN, DMEM_WAIT. Reset value: RUN.
- Reset (rst_i high at a clock edge): state = RUN; all counters = 0; wait counter = 0; dmem_timeout_o = 0.
- Combinational outputs while rst_i is high: PCWrite_o = 0, IFIDWrite_o = 0, NoOp_o = 1, IFID_flush_o = 0, stall_all_o = 1.
- Freeze condition: freeze = (state == RUN && MemReq_EXMEM && !dmem_ready_i) || (state == DMEM_WAIT && !dmem_ready_i).
- FSM transitions:
  - RUN -> DMEM_WAIT when MemReq_EXMEM && !dmem_ready_i.
  - DMEM_WAIT -> RUN in the cycle dmem_ready_i = 1; freeze is 0 in that cycle.
  - dmem_ready_i = 1 on a MemReq_EXMEM cycle in RUN is a zero-wait access: no freeze, no state change.
- Load-use condition: lu = MemRead_IDEX && rd_IDEX != 0 && (rd_IDEX == rs1_IFID || (use_rs2_IFID && rd_IDEX == rs2_IFID)).
- Output priority is freeze > load-use > flush:
  - freeze: stall_all_o = 1, PCWrite_o = 0, IFIDWrite_o = 0, NoOp_o = 0, IFID_flush_o = 0. A taken branch is deferred; it is re-presented after the freeze because ID is frozen.
  - lu (no freeze): PCWrite_o = 0, IFIDWrite_o = 0, NoOp_o = 1, IFID_flush_o = 0. The branch waits on its operand. Exactly one bubble per load; the next cycle rd_IDEX holds the bubble.
  - branch_taken_i (neither of the above): IFID_flush_o = 1, PCWrite_o = 1, IFIDWrite_o = 1.
  - none of the above: PCWrite_o = 1, IFIDWrite_o = 1, all other control outputs 0.
- All control outputs are combinational, with zero latency from inputs and state.
- Counters:
  - Updated at the clock edge on the final output values: +1 per cycle with NoOp_o, stall_all_o or IFID_flush_o respectively.
  - Each counter saturates at 2^CNT_W - 1; no wrap.
  - Counters are registered outputs, visible one cycle after the event.
- Watchdog:
  - The wait counter clears on entry to DMEM_WAIT and increments each DMEM_WAIT cycle.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT: dmem_timeout_o = 1 (sticky until reset). The FSM stays in DMEM_WAIT.
- Reset mid-freeze returns the FSM to RUN immediately. Outputs follow the reset values above during the reset cycle.

Decomposition:
- Shared cpu_pkg: state enum {RUN, DMEM_WAIT}; constant REG_ZERO = 5'd0; typedef for register index (5 bits).
- One sub-module: sat_counter (parameter W; inputs clk_i, rst_i, inc; output count), instantiated three times.

Test Plan:
- lw x5 in EX with MemRead_IDEX = 1, rd_IDEX = 5; rs1_IFID = 5 -> one cycle PCWrite_o = 0, IFIDWrite_o = 0, NoOp_o = 1; stall_cnt_o goes 0 -> 1. Same with rd_IDEX = 0, or rs2 match with use_rs2_IFID = 0 -> no stall.
- branch_taken_i = 1 with no hazard -> IFID_flush_o = 1 for one cycle; flush_cnt_o = 1 next cycle.
- MemReq_EXMEM = 1 with dmem_ready_i low for 3 cycles, then high -> stall_all_o high for exactly 3 cycles, low in the ready cycle; freeze_cnt_o = 3; state returns to RUN.
- Freeze, load-use and branch_taken_i asserted together -> only stall_all_o = 1 active; once freeze ends, NoOp_o = 1 is asserted first, then the flush.
- TIMEOUT = 4, dmem_ready_i held low -> dmem_timeout_o rises after 4 wait cycles and stays set after ready returns; only rst_i clears it.
- Assert rst_i during DMEM_WAIT -> state RUN, all counters 0, flag 0; force counters near 2^CNT_W - 1 (CNT_W = 4) -> value holds at 15.
